// File: rtl/cpu_controller.sv
// Multicycle Moore sequencer for the 16-bit RISC datapath: fetch, PC update, decode, execute.
// Latency: 5-10 cycles per instruction with mem_ready=1; each mem_ready=0 cycle adds one.
// Backpressure: stalls in IF1/MEM_RD/MEM_WR until mem_ready; HALT exits only through reset.
module cpu_controller (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  input  logic       mem_ready,
  output logic [2:0] nsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic [1:0] vsel,
  output logic       write,
  output logic       load_ir,
  output logic       load_pc,
  output logic       reset_pc,
  output logic       load_addr,
  output logic       addr_sel,
  output logic [1:0] mem_cmd,
  output logic       halted,
  output logic       illegal
);

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  typedef enum logic [4:0] {
    RST, IF1, IF2, UPDATEPC, DECODE, WRITE_IMM, GETA, GETB, ALU, ALU_CMP,
    ALU_PASS, ALU_PASS_ST, WRITE_C, ADDR, LOAD_ADDR, GET_RD, MEM_RD,
    WRITE_MEM, MEM_WR, HALT, ILLEGAL
  } state_t;

  state_t state, state_nxt;

  logic [4:0] ins;
  logic is_movi, is_movr, is_alu2, is_cmp, is_mvn, is_ldr, is_str, is_halt;

  assign ins     = {opcode, op};
  assign is_movi = (ins == 5'b110_10);
  assign is_movr = (ins == 5'b110_00);
  assign is_alu2 = (ins == 5'b101_00) || (ins == 5'b101_10);
  assign is_cmp  = (ins == 5'b101_01);
  assign is_mvn  = (ins == 5'b101_11);
  assign is_ldr  = (ins == 5'b011_00);
  assign is_str  = (ins == 5'b100_00);
  assign is_halt = (opcode == 3'b111);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RST;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = RST;
    nsel      = 3'b000;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    vsel      = 2'b00;
    write     = 1'b0;
    load_ir   = 1'b0;
    load_pc   = 1'b0;
    reset_pc  = 1'b0;
    load_addr = 1'b0;
    addr_sel  = 1'b0;
    mem_cmd   = MEM_NONE;
    halted    = 1'b0;
    illegal   = 1'b0;

    case (state)
      RST: begin
        reset_pc  = 1'b1;
        load_pc   = 1'b1;
        state_nxt = IF1;
      end
      IF1: begin
        addr_sel  = 1'b1;
        mem_cmd   = MEM_READ;
        state_nxt = mem_ready ? IF2 : IF1;
      end
      IF2: begin
        addr_sel  = 1'b1;
        mem_cmd   = MEM_READ;
        load_ir   = 1'b1;
        state_nxt = UPDATEPC;
      end
      UPDATEPC: begin
        load_pc   = 1'b1;
        state_nxt = DECODE;
      end
      DECODE: begin
        if (is_movi)                               state_nxt = WRITE_IMM;
        else if (is_movr || is_mvn)                state_nxt = GETB;
        else if (is_alu2 || is_cmp || is_ldr || is_str) state_nxt = GETA;
        else if (is_halt)                          state_nxt = HALT;
        else                                       state_nxt = ILLEGAL;
      end
      WRITE_IMM: begin
        nsel      = 3'b001;
        vsel      = 2'b10;
        write     = 1'b1;
        state_nxt = IF1;
      end
      GETA: begin
        nsel      = 3'b001;
        loada     = 1'b1;
        state_nxt = (is_ldr || is_str) ? ADDR : GETB;
      end
      GETB: begin
        nsel  = 3'b100;
        loadb = 1'b1;
        if (is_movr)     state_nxt = ALU_PASS;
        else if (is_cmp) state_nxt = ALU_CMP;
        else             state_nxt = ALU;
      end
      ALU: begin
        loadc     = 1'b1;
        loads     = 1'b1;
        state_nxt = WRITE_C;
      end
      // CMP only updates status; C is left untouched
      ALU_CMP: begin
        loads     = 1'b1;
        state_nxt = IF1;
      end
      ALU_PASS: begin
        asel      = 1'b1;
        loadc     = 1'b1;
        state_nxt = WRITE_C;
      end
      ALU_PASS_ST: begin
        asel      = 1'b1;
        loadc     = 1'b1;
        state_nxt = MEM_WR;
      end
      WRITE_C: begin
        nsel      = 3'b010;
        write     = 1'b1;
        state_nxt = IF1;
      end
      ADDR: begin
        bsel      = 1'b1;
        loadc     = 1'b1;
        state_nxt = LOAD_ADDR;
      end
      LOAD_ADDR: begin
        load_addr = 1'b1;
        state_nxt = is_str ? GET_RD : MEM_RD;
      end
      GET_RD: begin
        nsel      = 3'b010;
        loadb     = 1'b1;
        state_nxt = ALU_PASS_ST;
      end
      MEM_RD: begin
        mem_cmd   = MEM_READ;
        state_nxt = mem_ready ? WRITE_MEM : MEM_RD;
      end
      WRITE_MEM: begin
        mem_cmd   = MEM_READ;
        nsel      = 3'b010;
        vsel      = 2'b11;
        write     = 1'b1;
        state_nxt = IF1;
      end
      MEM_WR: begin
        mem_cmd   = MEM_WRITE;
        state_nxt = mem_ready ? IF1 : MEM_WR;
      end
      HALT: begin
        halted    = 1'b1;
        state_nxt = HALT;
      end
      ILLEGAL: begin
        illegal   = 1'b1;
        state_nxt = IF1;
      end
      // unused encodings fall back to RST
      default: state_nxt = RST;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Randomized bench for cpu_controller: per-instruction expected output traces built from the opcode map.
module tb_cpu_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       mem_ready;
  logic [2:0] nsel;
  logic       loada, loadb, loadc, loads, asel, bsel;
  logic [1:0] vsel;
  logic       write, load_ir, load_pc, reset_pc, load_addr, addr_sel;
  logic [1:0] mem_cmd;
  logic       halted, illegal;

  int n_vec  = 0;
  int n_miss = 0;

  cpu_controller dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .op(op), .mem_ready(mem_ready),
    .nsel(nsel), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .write(write), .load_ir(load_ir),
    .load_pc(load_pc), .reset_pc(reset_pc), .load_addr(load_addr), .addr_sel(addr_sel),
    .mem_cmd(mem_cmd), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  logic [20:0] obs;
  assign obs = {nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write,
                load_ir, load_pc, reset_pc, load_addr, addr_sel, mem_cmd, halted, illegal};

  // ld = {loada,loadb,loadc,loads}; ctl = {load_ir,load_pc,reset_pc,load_addr,addr_sel}
  function automatic logic [20:0] mk(input logic [2:0] ns, input logic [3:0] ld, input logic as,
                                     input logic bs, input logic [1:0] vs, input logic wr,
                                     input logic [4:0] ctl, input logic [1:0] mem,
                                     input logic hl, input logic il);
    return {ns, ld, as, bs, vs, wr, ctl, mem, hl, il};
  endfunction

  localparam logic [20:0] O_RST   = mk(3'b000, 4'b0000, 0, 0, 2'b00, 0, 5'b01100, 2'b00, 0, 0);
  localparam logic [20:0] O_IF1   = mk(3'b000, 4'b0000, 0, 0, 2'b00, 0, 5'b00001, 2'b01, 0, 0);
  localparam logic [20:0] O_IF2   = mk(3'b000, 4'b0000, 0, 0, 2'b00, 0, 5'b10001, 2'b01, 0, 0);
  localparam logic [20:0] O_UPC   = mk(3'b000, 4'b0000, 0, 0, 2'b00, 0, 5'b01000, 2'b00, 0, 0);
  localparam logic [20:0] O_DEC   = 21'd0;
  localparam logic [20:0] O_WIMM  = mk(3'b001, 4'b0000, 0, 0, 2'b10, 1, 5'b00000, 2'b00, 0, 0);
  localparam logic [20:0] O_GETA  = mk(3'b001, 4'b1000, 0, 0, 2'b00, 0, 5'b00000, 2'b00, 0, 0);
  localparam logic [20:0] O_GETB  = mk(3'b100, 4'b0100, 0, 0, 2'b00, 0, 5'b00000, 2'b00, 0, 0);
  localparam logic [20:0] O_ALU   = mk(3'b000, 4'b0011, 0, 0, 2'b00, 0, 5'b00000, 2'b00, 0, 0);
  localparam logic [20:0] O_CMP   = mk(3'b000, 4'b0001, 0, 0, 2'b00, 0, 5'b00000, 2'b00, 0, 0);
  localparam logic [20:0] O_PASS  = mk(3'b000, 4'b0010, 1, 0, 2'b00, 0, 5'b00000, 2'b00, 0, 0);
  localparam logic [20:0] O_WRC   = mk(3'b010, 4'b0000, 0, 0, 2'b00, 1, 5'b00000, 2'b00, 0, 0);
  localparam logic [20:0] O_ADDR  = mk(3'b000, 4'b0010, 0, 1, 2'b00, 0, 5'b00000, 2'b00, 0, 0);
  localparam logic [20:0] O_LADDR = mk(3'b000, 4'b0000, 0, 0, 2'b00, 0, 5'b00010, 2'b00, 0, 0);
  localparam logic [20:0] O_GETRD = mk(3'b010, 4'b0100, 0, 0, 2'b00, 0, 5'b00000, 2'b00, 0, 0);
  localparam logic [20:0] O_MRD   = mk(3'b000, 4'b0000, 0, 0, 2'b00, 0, 5'b00000, 2'b01, 0, 0);
  localparam logic [20:0] O_WMEM  = mk(3'b010, 4'b0000, 0, 0, 2'b11, 1, 5'b00000, 2'b01, 0, 0);
  localparam logic [20:0] O_MWR   = mk(3'b000, 4'b0000, 0, 0, 2'b00, 0, 5'b00000, 2'b10, 0, 0);
  localparam logic [20:0] O_HALT  = mk(3'b000, 4'b0000, 0, 0, 2'b00, 0, 5'b00000, 2'b00, 1, 0);
  localparam logic [20:0] O_ILL   = mk(3'b000, 4'b0000, 0, 0, 2'b00, 0, 5'b00000, 2'b00, 0, 1);

  typedef struct {
    logic [20:0] v;
    logic        rdy;
  } step_t;

  step_t q[$];

  task automatic push(input logic [20:0] v, input logic rdy);
    step_t s;
    s.v   = v;
    s.rdy = rdy;
    q.push_back(s);
  endtask

  // mem_ready is don't-care outside the wait states, so it is randomized there
  task automatic push_any(input logic [20:0] v);
    push(v, 1'($urandom_range(0, 1)));
  endtask

  task automatic push_wait(input logic [20:0] v, input int waits);
    for (int k = 0; k < waits; k++) push(v, 1'b0);
    push(v, 1'b1);
  endtask

  task automatic check(input string tag, input int cyc, input logic [20:0] want);
    n_vec++;
    assert (obs === want)
    else begin
      n_miss++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, want);
    end
  endtask

  // Builds the expected trace for one instruction and plays it; limit>0 stops early with no final edge.
  task automatic exec(input string tag, input logic [2:0] opc, input logic [1:0] opv,
                      input int wif, input int wmem, input int nhalt, input int limit);
    int n;
    q.delete();
    push_wait(O_IF1, wif);
    push_any(O_IF2);
    push_any(O_UPC);
    push_any(O_DEC);
    casez ({opc, opv})
      5'b110_10: push_any(O_WIMM);
      5'b110_00: begin push_any(O_GETB); push_any(O_PASS); push_any(O_WRC); end
      5'b101_00, 5'b101_10: begin
        push_any(O_GETA); push_any(O_GETB); push_any(O_ALU); push_any(O_WRC);
      end
      5'b101_01: begin push_any(O_GETA); push_any(O_GETB); push_any(O_CMP); end
      5'b101_11: begin push_any(O_GETB); push_any(O_ALU); push_any(O_WRC); end
      5'b011_00: begin
        push_any(O_GETA); push_any(O_ADDR); push_any(O_LADDR);
        push_wait(O_MRD, wmem); push_any(O_WMEM);
      end
      5'b100_00: begin
        push_any(O_GETA); push_any(O_ADDR); push_any(O_LADDR);
        push_any(O_GETRD); push_any(O_PASS); push_wait(O_MWR, wmem);
      end
      5'b111_??: for (int k = 0; k < nhalt; k++) push_any(O_HALT);
      default:   push_any(O_ILL);
    endcase
    opcode = opc;
    op     = opv;
    n = (limit > 0 && limit < q.size()) ? limit : q.size();
    for (int i = 0; i < n; i++) begin
      check(tag, i, q[i].v);
      mem_ready = q[i].rdy;
      if (!(limit > 0 && i == n - 1)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #1;
    check(tag, 0, O_RST);
    @(posedge clk);
    #1;
    check(tag, 1, O_RST);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n   = 1'b1;
    mem_ready = 1'b0;
    opcode    = 3'b000;
    op        = 2'b00;
    #1;
    do_reset("reset");

    exec("movi", 3'b110, 2'b10, 0, 0, 0, 0);
    exec("add",  3'b101, 2'b00, 0, 0, 0, 0);
    exec("cmp",  3'b101, 2'b01, 0, 0, 0, 0);
    exec("and",  3'b101, 2'b10, 0, 0, 0, 0);
    exec("mvn",  3'b101, 2'b11, 0, 0, 0, 0);
    exec("movr", 3'b110, 2'b00, 0, 0, 0, 0);
    exec("ldr",  3'b011, 2'b00, 3, 2, 0, 0);
    exec("str",  3'b100, 2'b00, 0, 4, 0, 0);
    exec("ill",  3'b000, 2'b00, 0, 0, 0, 0);

    // async reset while sitting in GETB of a MOV reg
    exec("movr_abort", 3'b110, 2'b00, 0, 0, 0, 5);
    #1;
    do_reset("reset_mid");
    exec("post_reset", 3'b110, 2'b10, 0, 0, 0, 0);

    for (int t = 0; t < 60; t++) begin
      exec("rand", 3'($urandom_range(0, 6)), 2'($urandom_range(0, 3)),
           $urandom_range(0, 3), $urandom_range(0, 3), 0, 0);
    end

    exec("halt", 3'b111, 2'($urandom_range(0, 3)), 1, 0, 21, 0);
    do_reset("reset_halt");
    exec("after_halt", 3'b101, 2'b00, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
